// File: rtl/visor_debug_pkg.sv
// Shared definitions for the supervisor debug link (target responder and
// visor-side register decode).
package visor_debug_pkg;

    // Bit positions inside the tg_force control word
    localparam int HOLD_STATE     = 0;
    localparam int FORCE_LOAD_EXR = 1;
    localparam int FORCE_EXEC     = 2;

    // Breakpoint address value that turns a comparator off
    localparam logic [15:0] BP_DISABLE = 16'hffff;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } dbg_state_e;

endpackage

// File: rtl/target_debug_responder_if.sv
// Target-side bus between the MCU core and the debug responder: instruction
// fetch reporting, debug_peek_reg writes, and the hold/force controls back.
interface target_debug_responder_if #(
    parameter int W = 16
);
    logic         tg_fetch_valid;
    logic [W-1:0] tg_fetch_addr;
    logic [W-1:0] tg_code_data;
    logic         peek_wr;
    logic [W-1:0] peek_wdata;
    logic         tg_hold;
    logic         tg_exr_load;
    logic [W-1:0] tg_exr_data;
    logic         tg_exec_force;

    // Target core side
    modport master (
        output tg_fetch_valid, tg_fetch_addr, tg_code_data, peek_wr, peek_wdata,
        input  tg_hold, tg_exr_load, tg_exr_data, tg_exec_force
    );

    // Debug responder side
    modport slave (
        input  tg_fetch_valid, tg_fetch_addr, tg_code_data, peek_wr, peek_wdata,
        output tg_hold, tg_exr_load, tg_exr_data, tg_exec_force
    );
endinterface

// File: rtl/target_debug_responder_bp_comparator.sv
// One breakpoint slot: address register, pass-once skip flag, sticky hit
// flag and the fetch-address match.
module bp_comparator #(
    parameter int           W          = 16,
    parameter logic [W-1:0] BP_DISABLE = 16'hffff
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tg_reset,
    input  logic         wr,
    input  logic [W-1:0] wdata,
    input  logic         halted,
    input  logic         eval,
    input  logic [W-1:0] fetch_addr,
    output logic [W-1:0] addr,
    output logic         status,
    output logic         match
);
    logic [W-1:0] addr_q, addr_d;
    logic         skip_q, skip_d;
    logic         status_q, status_d;

    // Hit on an evaluated fetch; a write to this slot in the same cycle wins
    always_comb begin
        match = eval && !wr && !skip_q &&
                (addr_q == fetch_addr) && (addr_q != BP_DISABLE);
    end

    // Next-state for address, skip and status; target reset beats everything
    always_comb begin
        addr_d   = addr_q;
        skip_d   = skip_q;
        status_d = status_q;
        if (tg_reset) begin
            skip_d   = 1'b0;
            status_d = 1'b0;
        end else begin
            if (wr) begin
                addr_d = wdata;
            end
            if (wr && halted) begin
                // Release: clear the hit and let the next fetch pass once
                skip_d   = 1'b1;
                status_d = 1'b0;
            end else begin
                if (eval) begin
                    skip_d = 1'b0;
                end
                if (match) begin
                    status_d = 1'b1;
                end
            end
        end
    end

    // Slot registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q   <= BP_DISABLE;
            skip_q   <= 1'b0;
            status_q <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            skip_q   <= skip_d;
            status_q <= status_d;
        end
    end

    assign addr   = addr_q;
    assign status = status_q;

endmodule

// File: rtl/target_debug_responder.sv
// Target-side debug responder: breakpoint compare on instruction fetches,
// halt FSM, forced exr load/execute pulses, exr shadow and peek capture.
module target_debug_responder #(
    parameter int           NUM_BP     = 4,
    parameter int           W          = 16,
    parameter logic [W-1:0] BP_DISABLE = 16'hffff
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tg_reset,
    input  logic [NUM_BP-1:0]     bp_wr,
    input  logic [W-1:0]          bp_wdata,
    output logic [NUM_BP*W-1:0]   bp_addr,
    output logic [NUM_BP-1:0]     bp_status,
    input  logic [2:0]            tg_force,
    input  logic [W-1:0]          force_opcode,
    output logic [W-1:0]          exr_shadow,
    output logic [W-1:0]          peek_data,
    target_debug_responder_if.slave tg
);
    import visor_debug_pkg::*;

    dbg_state_e   state_q, state_d;
    logic [NUM_BP-1:0] match_vec;
    logic         halted;
    logic         hold;
    logic         eval;

    logic [1:0]   force_prev_q, force_prev_d;
    logic         exr_load_q, exr_load_d;
    logic         exec_force_q, exec_force_d;
    logic [W-1:0] exr_data_q, exr_data_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] peek_q, peek_d;

    assign halted = (state_q == ST_HALTED);
    // Fetches seen while the target is held are protocol violations: no compare
    assign eval   = tg.tg_fetch_valid && !hold;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BP; gi++) begin : g_bp
            bp_comparator #(
                .W          (W),
                .BP_DISABLE (BP_DISABLE)
            ) u_bp (
                .clk        (clk),
                .rst_n      (rst_n),
                .tg_reset   (tg_reset),
                .wr         (bp_wr[gi]),
                .wdata      (bp_wdata),
                .halted     (halted),
                .eval       (eval),
                .fetch_addr (tg.tg_fetch_addr),
                .addr       (bp_addr[gi*W +: W]),
                .status     (bp_status[gi]),
                .match      (match_vec[gi])
            );
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: halt on any hit, resume on any breakpoint write
    always_comb begin
        state_d = state_q;
        if (tg_reset) begin
            state_d = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:    if (|match_vec) state_d = ST_HALTED;
                ST_HALTED: if (|bp_wr)     state_d = ST_RUN;
                default:   state_d = ST_RUN;
            endcase
        end
    end

    // FSM outputs: hold while halted or while the visor forces it
    always_comb begin
        hold = halted || tg_force[HOLD_STATE];
    end

    // Force edge detection, shadow and peek capture
    always_comb begin
        force_prev_d = {tg_force[FORCE_EXEC], tg_force[FORCE_LOAD_EXR]};
        exr_load_d   = 1'b0;
        exec_force_d = 1'b0;
        exr_data_d   = exr_data_q;
        shadow_d     = shadow_q;
        peek_d       = peek_q;
        if (tg_reset) begin
            exr_data_d = '0;
            shadow_d   = '0;
            peek_d     = '0;
        end else begin
            // Edges are only acted on while held and never queued for later
            exr_load_d   = hold && tg_force[FORCE_LOAD_EXR] && !force_prev_q[0];
            exec_force_d = hold && tg_force[FORCE_EXEC]     && !force_prev_q[1];
            if (exr_load_d) begin
                exr_data_d = force_opcode;
            end
            if (tg.tg_fetch_valid) begin
                shadow_d = tg.tg_code_data;
            end
            if (tg.peek_wr) begin
                peek_d = tg.peek_wdata;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            force_prev_q <= '0;
            exr_load_q   <= 1'b0;
            exec_force_q <= 1'b0;
            exr_data_q   <= '0;
            shadow_q     <= '0;
            peek_q       <= '0;
        end else begin
            force_prev_q <= force_prev_d;
            exr_load_q   <= exr_load_d;
            exec_force_q <= exec_force_d;
            exr_data_q   <= exr_data_d;
            shadow_q     <= shadow_d;
            peek_q       <= peek_d;
        end
    end

    assign tg.tg_hold       = hold;
    assign tg.tg_exr_load   = exr_load_q;
    assign tg.tg_exr_data   = exr_data_q;
    assign tg.tg_exec_force = exec_force_q;
    assign exr_shadow       = shadow_q;
    assign peek_data        = peek_q;

endmodule

// File: tb/tb_target_debug_responder.sv
// Directed bench for target_debug_responder.
module tb_target_debug_responder;

    localparam int NUM_BP = 4;
    localparam int W      = 16;

    logic              clk;
    logic              rst_n;
    logic              tg_reset;
    logic [NUM_BP-1:0] bp_wr;
    logic [W-1:0]      bp_wdata;
    logic [NUM_BP*W-1:0] bp_addr;
    logic [NUM_BP-1:0] bp_status;
    logic [2:0]        tg_force;
    logic [W-1:0]      force_opcode;
    logic [W-1:0]      exr_shadow;
    logic [W-1:0]      peek_data;

    int n_cmp;
    int n_bad;

    target_debug_responder_if #(.W(W)) tg ();

    target_debug_responder #(
        .NUM_BP     (NUM_BP),
        .W          (W),
        .BP_DISABLE (16'hffff)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tg_reset     (tg_reset),
        .bp_wr        (bp_wr),
        .bp_wdata     (bp_wdata),
        .bp_addr      (bp_addr),
        .bp_status    (bp_status),
        .tg_force     (tg_force),
        .force_opcode (force_opcode),
        .exr_shadow   (exr_shadow),
        .peek_data    (peek_data),
        .tg           (tg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
        $display("check %-14s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bp_write(input logic [NUM_BP-1:0] sel, input logic [W-1:0] data);
        bp_wr    = sel;
        bp_wdata = data;
        tick();
        bp_wr    = '0;
    endtask

    task automatic fetch(input logic [W-1:0] addr, input logic [W-1:0] data);
        tg.tg_fetch_valid = 1'b1;
        tg.tg_fetch_addr  = addr;
        tg.tg_code_data   = data;
        tick();
        tg.tg_fetch_valid = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b0;
        tg_reset = 1'b0;
        bp_wr = '0;
        bp_wdata = '0;
        tg_force = '0;
        force_opcode = '0;
        tg.tg_fetch_valid = 1'b0;
        tg.tg_fetch_addr = '0;
        tg.tg_code_data = '0;
        tg.peek_wr = 1'b0;
        tg.peek_wdata = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Reset state
        chk("rst_bp_addr", bp_addr, 64'hffff_ffff_ffff_ffff);
        chk("rst_status", bp_status, 4'b0000);
        chk("rst_hold", tg.tg_hold, 1'b0);
        chk("rst_exr_load", tg.tg_exr_load, 1'b0);
        chk("rst_exec", tg.tg_exec_force, 1'b0);
        chk("rst_exr_data", tg.tg_exr_data, 16'h0000);
        chk("rst_shadow", exr_shadow, 16'h0000);
        chk("rst_peek", peek_data, 16'h0000);

        // Basic hit on bp0
        bp_write(4'b0001, 16'h0015);
        chk("bp0_written", bp_addr, 64'hffff_ffff_ffff_0015);
        fetch(16'h0014, 16'h1111);
        chk("miss_status", bp_status, 4'b0000);
        chk("miss_hold", tg.tg_hold, 1'b0);
        chk("miss_shadow", exr_shadow, 16'h1111);
        fetch(16'h0015, 16'hABCD);
        chk("hit_status", bp_status, 4'b0001);
        chk("hit_hold", tg.tg_hold, 1'b1);
        chk("hit_shadow", exr_shadow, 16'hABCD);

        // Forced load / execute while halted
        force_opcode = 16'h7c07;
        tg_force = 3'b001;
        tick();
        chk("f1_load", tg.tg_exr_load, 1'b0);
        tg_force = 3'b011;
        tick();
        chk("f3_load", tg.tg_exr_load, 1'b1);
        chk("f3_data", tg.tg_exr_data, 16'h7c07);
        chk("f3_exec", tg.tg_exec_force, 1'b0);
        tg_force = 3'b101;
        tick();
        chk("f5_load", tg.tg_exr_load, 1'b0);
        chk("f5_exec", tg.tg_exec_force, 1'b1);
        tg_force = 3'b001;
        tick();
        chk("f1b_load", tg.tg_exr_load, 1'b0);
        chk("f1b_exec", tg.tg_exec_force, 1'b0);
        tg.peek_wr = 1'b1;
        tg.peek_wdata = 16'h1234;
        tick();
        tg.peek_wr = 1'b0;
        chk("peek", peek_data, 16'h1234);
        chk("shadow_kept", exr_shadow, 16'hABCD);
        tg_force = 3'b000;
        tick();
        chk("still_halted", tg.tg_hold, 1'b1);

        // Pass-once release with the same address
        bp_write(4'b0001, 16'h0015);
        chk("rel_hold", tg.tg_hold, 1'b0);
        chk("rel_status", bp_status, 4'b0000);
        fetch(16'h0015, 16'h2222);
        chk("skip_hold", tg.tg_hold, 1'b0);
        chk("skip_status", bp_status, 4'b0000);
        fetch(16'h0016, 16'h3333);
        chk("f16_hold", tg.tg_hold, 1'b0);
        fetch(16'h0015, 16'h4444);
        chk("rehit_hold", tg.tg_hold, 1'b1);
        chk("rehit_status", bp_status, 4'b0001);

        // Release, then two comparators on the same address
        bp_write(4'b0001, 16'h0030);
        chk("rel2_hold", tg.tg_hold, 1'b0);
        fetch(16'h0000, 16'h0000);
        bp_write(4'b0101, 16'h0020);
        fetch(16'h0020, 16'h5555);
        chk("dual_status", bp_status, 4'b0101);
        chk("dual_hold", tg.tg_hold, 1'b1);

        // Release through bp1 (status of 0 and 2 untouched)
        bp_write(4'b0010, 16'hffff);
        chk("rel3_hold", tg.tg_hold, 1'b0);
        chk("rel3_status", bp_status, 4'b0101);

        // Force-load edge while running is ignored
        tg_force = 3'b010;
        tick();
        chk("run_load_a", tg.tg_exr_load, 1'b0);
        tick();
        chk("run_load_b", tg.tg_exr_load, 1'b0);
        tg_force = 3'b000;
        tick();

        // Target reset while halted
        fetch(16'h0000, 16'h0000);
        fetch(16'h0020, 16'h6666);
        chk("pre_trst_hold", tg.tg_hold, 1'b1);
        tg_reset = 1'b1;
        tick();
        tg_reset = 1'b0;
        chk("trst_hold", tg.tg_hold, 1'b0);
        chk("trst_status", bp_status, 4'b0000);
        chk("trst_bp_addr", bp_addr, 64'hffff_0020_ffff_0020);
        chk("trst_shadow", exr_shadow, 16'h0000);
        chk("trst_peek", peek_data, 16'h0000);

        // Asynchronous reset in the middle of a halt
        fetch(16'h0020, 16'h7777);
        chk("pre_rst_hold", tg.tg_hold, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_bp_addr", bp_addr, 64'hffff_ffff_ffff_ffff);
        chk("arst_status", bp_status, 4'b0000);
        chk("arst_hold", tg.tg_hold, 1'b0);
        chk("arst_shadow", exr_shadow, 16'h0000);
        chk("arst_exr_data", tg.tg_exr_data, 16'h0000);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
